// File: rtl/ps2_packet_ctrl.sv
// PS/2 mouse receiver: synchronizes the line, checks 11-bit frames, assembles movement packets.
// Define PS2_WHEEL_EN for 4-byte wheel packets and the extra dz output.
module ps2_packet_ctrl #(
    parameter int TIMEOUT_CYC = 3400,
    parameter int GAP_CYC     = 100000,
    parameter int CW          = 17
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       pkt_ready,
    output logic       pkt_valid,
    output logic [2:0] btn,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic [1:0] ovf,
`ifdef PS2_WHEEL_EN
    output logic [3:0] dz,
`endif
    output logic [3:0] err
);

`ifdef PS2_WHEEL_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd2;
`endif
    localparam logic [CW-1:0] TO_TERM  = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] GAP_TERM = CW'(GAP_CYC);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_clk_s1, r_clk_s2, r_clk_prev;
    logic          r_dat_s1, r_dat_s2;
    logic          w_edge;
    logic          w_sample;
    logic          w_timeout;
    logic          w_gap_expire;
    logic          w_check;
    logic          w_frame_ok;
    logic          w_keep;
    logic          w_last;
    logic [7:0]    w_byte;
    logic [10:0]   r_shift;
    logic [3:0]    r_bit_cnt;
    logic [CW-1:0] r_wdog;
    logic [1:0]    r_idx;
    logic [6:0]    r_hdr;
    logic [7:0]    r_b1;
`ifdef PS2_WHEEL_EN
    logic [7:0]    r_b2;
    logic [3:0]    r_dz;
`endif
    logic          r_pkt_valid;
    logic [2:0]    r_btn;
    logic [8:0]    r_dx;
    logic [8:0]    r_dy;
    logic [1:0]    r_ovf;
    logic [3:0]    r_err;

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            // NOTE: non-blocking so each stage takes the previous cycle's value; blocking would collapse the chain into one flop.
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_edge = r_clk_prev & ~r_clk_s2;

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next    = r_state;
        w_sample  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_sample = 1'b1;
                    w_next   = S_RECV;
                end
            end
            S_RECV: begin
                if (w_edge) begin
                    w_sample = 1'b1;
                    if (r_bit_cnt == 4'd10) w_next = S_CHECK;
                end else if (r_wdog == TO_TERM) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_CHECK: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Frame layout after 11 right-shifts: [0] start, [8:1] data, [9] parity, [10] stop.
    assign w_byte       = r_shift[8:1];
    assign w_frame_ok   = ~r_shift[0] & r_shift[10] & (^r_shift[9:1]);
    assign w_check      = (r_state == S_CHECK);
    assign w_keep       = w_check & w_frame_ok & ~((r_idx == 2'd0) & ~w_byte[3]);
    assign w_last       = (r_idx == LAST_IDX);
    assign w_gap_expire = (r_state == S_IDLE) & ~w_edge & (r_idx != 2'd0) & (r_wdog == GAP_TERM);

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_wdog    <= '0;
        end else begin
            if (w_sample) begin
                r_shift   <= {r_dat_s2, r_shift[10:1]};
                r_bit_cnt <= (r_state == S_IDLE) ? 4'd1 : r_bit_cnt + 4'd1;
            end
            // One counter serves both the in-frame timeout and the inter-byte gap; it saturates.
            if (w_sample || w_check) begin
                r_wdog <= '0;
            end else if (r_state == S_RECV) begin
                if (r_wdog != TO_TERM) r_wdog <= r_wdog + 1'b1;
            end else if (r_idx != 2'd0) begin
                if (r_wdog != GAP_TERM) r_wdog <= r_wdog + 1'b1;
            end else begin
                r_wdog <= '0;
            end
        end
    end

    // NOTE: the byte store has no reset: each slot is written before the packet that reads it completes.
    always_ff @(posedge ck) begin
        if (w_keep && !w_last) begin
            case (r_idx)
                2'd0:    r_hdr <= {w_byte[7:4], w_byte[2:0]};
                2'd1:    r_b1  <= w_byte;
`ifdef PS2_WHEEL_EN
                2'd2:    r_b2  <= w_byte;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            r_idx       <= '0;
            r_pkt_valid <= 1'b0;
            r_btn       <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_ovf       <= '0;
            r_err       <= '0;
`ifdef PS2_WHEEL_EN
            r_dz        <= '0;
`endif
        end else begin
            r_err <= '0;
            if (r_pkt_valid && pkt_ready) r_pkt_valid <= 1'b0;
            if (w_timeout) begin
                r_err[1] <= 1'b1;
                r_idx    <= '0;
            end else if (w_gap_expire) begin
                r_idx <= '0;
            end else if (w_check) begin
                if (!w_frame_ok) begin
                    r_err[0] <= 1'b1;
                    r_idx    <= '0;
                end else if (!w_keep) begin
                    r_err[2] <= 1'b1;
                end else if (w_last) begin
                    r_btn       <= r_hdr[2:0];
                    r_dx        <= {r_hdr[3], r_b1};
                    r_ovf       <= {r_hdr[6], r_hdr[5]};
`ifdef PS2_WHEEL_EN
                    r_dy        <= {r_hdr[4], r_b2};
                    r_dz        <= w_byte[3:0];
`else
                    r_dy        <= {r_hdr[4], w_byte};
`endif
                    r_pkt_valid <= 1'b1;
                    r_idx       <= '0;
                    // A same-cycle accept frees the slot, so only an unaccepted old packet is an overrun.
                    if (r_pkt_valid && !pkt_ready) r_err[3] <= 1'b1;
                end else begin
                    r_idx <= r_idx + 2'd1;
                end
            end
        end
    end

    assign pkt_valid = r_pkt_valid;
    assign btn       = r_btn;
    assign dx        = r_dx;
    assign dy        = r_dy;
    assign ovf       = r_ovf;
    assign err       = r_err;
`ifdef PS2_WHEEL_EN
    assign dz        = r_dz;
`endif

endmodule

// File: doc/ps2_packet_ctrl.md
Name: ps2_packet_ctrl

Overview:
- Sequences reception of PS/2 mouse frames and assembles complete movement packets for the rest of the design.
- Synchronizes the PS/2 clock and data lines and detects falling edges of the PS/2 clock.
- Counts the 11 bits of each frame, checks start/parity/stop, and runs a frame watchdog.
- Groups bytes into 3-byte packets (4 with the wheel option) and presents them through a valid/ready handshake.

Parameters:
- TIMEOUT_CYC, 3400: ck cycles with no PS/2 falling edge before an in-progress frame is aborted.
- GAP_CYC, 100000: ck cycles of idle between bytes before a partial packet is discarded.
- CW, 17: width of the shared watchdog counter; must hold max(TIMEOUT_CYC, GAP_CYC).

Ports:
- ck  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock line (asynchronous).
- ps2_data  in  1  raw PS/2 data line (asynchronous).
- pkt_ready  in  1  consumer accepts the packet when pkt_ready and pkt_valid are both high.
- pkt_valid  out  1  packet fields are valid; held until accepted.
- btn  out  3  buttons {middle,right,left} = byte0[2:0].
- dx  out  9  X movement, two's complement: {byte0[4], byte1}.
- dy  out  9  Y movement, two's complement: {byte0[5], byte2}.
- ovf  out  2  {byte0[7], byte0[6]} = {y overflow, x overflow}.
- err  out  4  one-cycle pulses {overrun, sync, timeout, frame}.

Behaviour:
- Reset (reset=0): state IDLE, byte index 0, all outputs 0, synchronizers preset to 1.
- Input sync: 2-flop synchronizer on each PS/2 line. Edge = previous synced clk 1 and current synced clk 0.
- Bit order: start, d0..d7 (LSB first), odd parity, stop. Bits are shifted into an internal 11-bit register on each edge.
- IDLE: on an edge, sample the bit, set bit count to 1, clear the watchdog, go to RECV.
- RECV: on each edge, sample the bit, increment the count, clear the watchdog. When the 11th bit is sampled, go to CHECK.
- RECV timeout: watchdog reaching TIMEOUT_CYC aborts the frame. Effects: err[1] pulse, byte index reset to 0, go to IDLE.
- CHECK (exactly 1 cycle): the frame is valid only if start=0, stop=1, and the XOR of data and parity is 1.
  - Invalid frame: err[0] pulse, byte index reset to 0, go to IDLE.
  - Valid frame, index 0, data[3]=0: err[2] (sync) pulse, byte discarded, index stays 0.
  - Otherwise: store the byte at the current index, then increment the index.
  - On the last byte: load the output fields, set pkt_valid, reset the index to 0.
- Latency: 11th edge detected at cycle N; CHECK at N+1; pkt_valid and fields updated at N+2.
- Handshake: fields stay stable while pkt_valid=1. Acceptance clears pkt_valid on the next ck.
- Overrun: a new packet completes while pkt_valid=1 and pkt_ready=0.
  - The new packet overwrites the fields, pkt_valid stays 1, err[3] pulses.
  - If pkt_ready=1 in that same cycle, the old packet counts as accepted: new packet loaded, no overrun.
- Gap watchdog: runs in IDLE while the index is non-zero. Reaching GAP_CYC resets the index to 0 with no error pulse.
- Watchdog saturates at its terminal count and never wraps.
- An edge arriving in CHECK is ignored. The device holds the line during this time, so no edge is expected.
- Mid-operation reset: immediate return to the reset state; a partial packet is lost.

Optional Feature:
- Macro: PS2_WHEEL_EN.
- Defined:
  - Packet length is 4 bytes.
  - Extra output port dz [3:0] = byte3[3:0], two's complement wheel movement.
  - pkt_valid is set after the 4th byte.
  - The gap watchdog also covers byte index 3.
- Undefined: packet length is 3 bytes and there is no dz port.

Test Plan:
- Clean packet: bytes 0x29, 0x05, 0xFE with correct parity -> pkt_valid at N+2; btn=3'b001, dx=9'h005, dy=9'h1FE, ovf=0, err=0.
- Bad parity on byte1 -> err[0] one-cycle pulse, index reset; the following valid 3-byte packet is decoded correctly.
- Byte0=0x01 (bit3=0) -> err[2] pulse, no pkt_valid; next 0x08, 0x00, 0x00 -> pkt_valid with all fields 0.
- PS/2 clock stops after 5 bits for TIMEOUT_CYC cycles -> err[1] pulse, state IDLE; next frame is received normally.
- pkt_ready held 0 across two packets -> second packet overwrites the fields, err[3] pulse, pkt_valid stays 1; pkt_ready=1 then clears it.
- reset asserted mid-frame after byte1 -> outputs 0 immediately; after release, a full packet decodes from byte 0.
